// File: rtl/button_conditioner_if.sv
// Pushbutton/switch bundle between the front-panel pins and the conditioner.
// master drives the raw pins; slave is the conditioner and drives the cleaned outputs.
interface button_conditioner_if;
  logic       Next_raw;
  logic       Pre_raw;
  logic       Verify_raw;
  logic       Reset_raw;
  logic       Stop_raw;
  logic       Next;
  logic       Pre;
  logic       Verify;
  logic       Reset;
  logic       Stop;
  logic [3:0] Level;

  modport master (
    output Next_raw, Pre_raw, Verify_raw, Reset_raw, Stop_raw,
    input  Next, Pre, Verify, Reset, Stop, Level
  );

  modport slave (
    input  Next_raw, Pre_raw, Verify_raw, Reset_raw, Stop_raw,
    output Next, Pre, Verify, Reset, Stop, Level
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects four pushbuttons and one slide switch.
// Optional auto-repeat on Next/Pre is enabled by defining BUTTON_CONDITIONER_AUTO_REPEAT_EN.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input logic                 CLK_in,
  input logic                 Reset_n,
  button_conditioner_if.slave btn
);

  localparam int unsigned NUM_IN     = 5;
  localparam int unsigned NUM_BTN    = 4;
  localparam int unsigned CNT_W      = 26;
  localparam int unsigned IDX_NEXT   = 0;
  localparam int unsigned IDX_PRE    = 1;
  localparam int unsigned IDX_VERIFY = 2;
  localparam int unsigned IDX_RESET  = 3;
  localparam int unsigned IDX_STOP   = 4;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES >= (32'(1) << CNT_W) ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("button_conditioner: parameter out of range");
  end

  logic [NUM_IN-1:0]  raw;
  logic [NUM_IN-1:0]  sync_meta;
  logic [NUM_IN-1:0]  sync;
  logic [NUM_IN-1:0]  level;
  logic [NUM_IN-1:0]  level_nxt;
  logic [NUM_BTN-1:0] level_prev;
  logic [NUM_BTN-1:0] rise;
  logic [CNT_W-1:0]   cnt     [NUM_IN];
  logic [CNT_W-1:0]   cnt_nxt [NUM_IN];
  logic [1:0]         rep_req;
  logic               req_next, req_pre, req_verify, req_reset;
  logic               next_q, pre_q, verify_q, reset_q;

  assign raw = {btn.Stop_raw, btn.Reset_raw, btn.Verify_raw, btn.Pre_raw, btn.Next_raw};

  // Two-flop synchronizer on every asynchronous pin
  always_ff @(posedge CLK_in or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      level_nxt[i] = level[i];
      cnt_nxt[i]   = '0;
      if (sync[i] != level[i]) begin
        if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) level_nxt[i] = ~level[i];
        else                                       cnt_nxt[i]   = cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_in or negedge Reset_n) begin
    if (!Reset_n) begin
      level      <= '0;
      level_prev <= '0;
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else begin
      level      <= level_nxt;
      level_prev <= level[NUM_BTN-1:0];
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign rise = level[NUM_BTN-1:0] & ~level_prev;

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam int unsigned TMR_W = 32;

  logic [TMR_W-1:0] rep_tmr [2];

  // Repeat fires when the countdown expires and the level is still held next cycle
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rep_req[i] = level_prev[i] & level[i] & level_nxt[i] & (rep_tmr[i] == '0);
    end
  end

  always_ff @(posedge CLK_in or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 2; i++) rep_tmr[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rise[i])            rep_tmr[i] <= TMR_W'(HOLD_CYCLES - 1);
        else if (!level_nxt[i]) rep_tmr[i] <= '0;
        else if (rep_req[i])    rep_tmr[i] <= TMR_W'(REPEAT_CYCLES - 1);
        else if (rep_tmr[i] != '0) rep_tmr[i] <= rep_tmr[i] - TMR_W'(1);
      end
    end
  end
`else
  assign rep_req = '0;
`endif

  assign req_next   = rise[IDX_NEXT] | rep_req[0];
  assign req_pre    = rise[IDX_PRE]  | rep_req[1];
  assign req_reset  = rise[IDX_RESET];
  assign req_verify = rise[IDX_VERIFY];

  // One pulse per cycle; lower-priority requests are dropped, not queued
  always_ff @(posedge CLK_in or negedge Reset_n) begin
    if (!Reset_n) begin
      next_q   <= 1'b0;
      pre_q    <= 1'b0;
      reset_q  <= 1'b0;
      verify_q <= 1'b0;
    end else begin
      next_q   <= req_next;
      pre_q    <= req_pre & ~req_next;
      reset_q  <= req_reset & ~req_next & ~req_pre;
      verify_q <= req_verify & ~req_next & ~req_pre & ~req_reset;
    end
  end

  assign btn.Next   = next_q;
  assign btn.Pre    = pre_q;
  assign btn.Reset  = reset_q;
  assign btn.Verify = verify_q;
  assign btn.Stop   = level[IDX_STOP];
  assign btn.Level  = level[NUM_BTN-1:0];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random pin activity,
// compared every cycle against a history-based reference model.
module tb_button_conditioner;

  localparam int D    = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int MAXE = 8192;
`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic CLK_in = 1'b0;
  logic Reset_n;

  always #5 CLK_in = ~CLK_in;

  button_conditioner_if bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .CLK_in (CLK_in),
    .Reset_n(Reset_n),
    .btn    (bif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: absolute histories of pin samples and debounced levels
  logic [4:0] raw_hist [MAXE];
  logic [4:0] lvl_hist [MAXE];
  int         edge_n   = 0;
  int         rst_last = 0;
  int         streak [5];
  int         press  [2];
  logic [8:0] exp_vec;

  int cyc;
  int next_cyc[$], pre_cyc[$], ver_cyc[$], rst_cyc[$];
  int lvl0_first, stop_first;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [4:0] raw_now();
    return {bif.Stop_raw, bif.Reset_raw, bif.Verify_raw, bif.Pre_raw, bif.Next_raw};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bif.Next, bif.Pre, bif.Verify, bif.Reset, bif.Stop, bif.Level};
  endfunction

  function automatic logic [4:0] raw_at(input int idx);
    return (idx > rst_last) ? raw_hist[idx] : 5'b0;
  endfunction

  function automatic logic [4:0] lvl_at(input int idx);
    return (idx > rst_last) ? lvl_hist[idx] : 5'b0;
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic model_clear();
    rst_last = edge_n;
    for (int i = 0; i < 5; i++) streak[i] = 0;
    for (int i = 0; i < 2; i++) press[i] = -1;
    exp_vec = '0;
  endtask

  task automatic model_edge();
    logic [4:0] samp, cur, bef, nl, rise;
    logic [1:0] rep;
    logic [3:0] req;
    int d;
    edge_n++;
    if (edge_n >= MAXE) begin
      $display("FAIL model_history: got %0d edges expected below %0d", edge_n, MAXE);
      $fatal(1);
    end
    raw_hist[edge_n] = raw_now();
    if (!Reset_n) begin
      model_clear();
      return;
    end
    samp = raw_at(edge_n - 2);
    cur  = lvl_at(edge_n - 1);
    bef  = lvl_at(edge_n - 2);
    nl   = cur;
    for (int i = 0; i < 5; i++) begin
      if (samp[i] != cur[i]) streak[i]++;
      else                   streak[i] = 0;
      if (streak[i] == D) begin
        nl[i]     = ~cur[i];
        streak[i] = 0;
      end
    end
    lvl_hist[edge_n] = nl;
    rise = cur & ~bef;
    rep  = '0;
    for (int i = 0; i < 2; i++) begin
      if (rise[i]) press[i] = edge_n;
      if (!nl[i])  press[i] = -1;
      if (AUTO && press[i] >= 0) begin
        d = edge_n - press[i];
        if (d >= HOLD && ((d - HOLD) % REP) == 0) rep[i] = 1'b1;
      end
    end
    req = {rise[3], rise[2], rise[1] | rep[1], rise[0] | rep[0]};
    exp_vec = {req[0],
               req[1] & ~req[0],
               req[2] & ~req[3] & ~req[1] & ~req[0],
               req[3] & ~req[1] & ~req[0],
               nl[4], nl[3:0]};
  endtask

  task automatic step();
    @(posedge CLK_in);
    model_edge();
    cyc++;
    #1;
    check("outs", 32'(dut_vec()), 32'(exp_vec));
    if (bif.Next)   next_cyc.push_back(cyc);
    if (bif.Pre)    pre_cyc.push_back(cyc);
    if (bif.Verify) ver_cyc.push_back(cyc);
    if (bif.Reset)  rst_cyc.push_back(cyc);
    if (bif.Level[0] && lvl0_first < 0) lvl0_first = cyc;
    if (bif.Stop && stop_first < 0)     stop_first = cyc;
  endtask

  task automatic start_scn();
    cyc = -1;
    next_cyc.delete();
    pre_cyc.delete();
    ver_cyc.delete();
    rst_cyc.delete();
    lvl0_first = -1;
    stop_first = -1;
  endtask

  task automatic assert_reset(input string tag);
    Reset_n = 1'b0;
    model_clear();
    #1;
    check(tag, 32'(dut_vec()), 32'd0);
  endtask

  task automatic apply_reset(input int n);
    assert_reset("rst_async");
    repeat (n) step();
    Reset_n = 1'b1;
  endtask

  task automatic set_raw(input logic [4:0] v);
    {bif.Stop_raw, bif.Reset_raw, bif.Verify_raw, bif.Pre_raw, bif.Next_raw} = v;
  endtask

  int exp_rep[$];
  int rem [5];
  logic [4:0] r;

  initial begin
    set_raw(5'b0);
    cyc = 0;
    apply_reset(2);

    // Single Next press, 30 cycles long
    bif.Next_raw = 1'b1;
    start_scn();
    repeat (30) step();
    bif.Next_raw = 1'b0;
    repeat (20) step();
    check("s1_next_cycle", 32'(qat(next_cyc, 0)), 32'd6);
    check("s1_next_count", 32'(next_cyc.size()), AUTO ? 32'd3 : 32'd1);
    check("s1_level0_rise", 32'(lvl0_first), 32'd5);

    // Short glitches are dropped, a long press is accepted once
    apply_reset(2);
    start_scn();
    bif.Pre_raw = 1'b1; repeat (2) step();
    bif.Pre_raw = 1'b0; repeat (1) step();
    bif.Pre_raw = 1'b1; repeat (2) step();
    bif.Pre_raw = 1'b0; repeat (8) step();
    check("s2_glitch_pre", 32'(pre_cyc.size()), 32'd0);
    bif.Pre_raw = 1'b1; repeat (10) step();
    bif.Pre_raw = 1'b0; repeat (15) step();
    check("s2_press_pre", 32'(pre_cyc.size()), 32'd1);

    // Simultaneous Next and Verify: Next wins, Verify is lost
    apply_reset(2);
    set_raw(5'b00101);
    start_scn();
    repeat (20) step();
    set_raw(5'b0);
    repeat (15) step();
    check("s3_next_cycle", 32'(qat(next_cyc, 0)), 32'd6);
    check("s3_verify_count", 32'(ver_cyc.size()), 32'd0);

    // Reset mid-debounce, button held through release
    apply_reset(2);
    bif.Reset_raw = 1'b1;
    start_scn();
    repeat (4) step();
    assert_reset("s4_async_mid");
    repeat (2) step();
    Reset_n = 1'b1;
    start_scn();
    repeat (12) step();
    check("s4_reset_cycle", 32'(qat(rst_cyc, 0)), 32'd6);
    check("s4_reset_count", 32'(rst_cyc.size()), 32'd1);
    check("s4_level_held", 32'(bif.Level), 32'h8);
    assert_reset("s4_async_level");
    repeat (2) step();
    bif.Reset_raw = 1'b0;
    Reset_n = 1'b1;

    // Long Next hold: auto-repeat pattern when enabled
    apply_reset(2);
    bif.Next_raw = 1'b1;
    start_scn();
    repeat (50) step();
    bif.Next_raw = 1'b0;
    repeat (30) step();
    exp_rep.delete();
    exp_rep.push_back(6);
    if (AUTO) begin
      exp_rep.push_back(26);
      exp_rep.push_back(34);
      exp_rep.push_back(42);
      exp_rep.push_back(50);
    end
    check("s5_next_count", 32'(next_cyc.size()), 32'(exp_rep.size()));
    for (int i = 0; i < exp_rep.size(); i++)
      check($sformatf("s5_next_%0d", i), 32'(qat(next_cyc, i)), 32'(exp_rep[i]));

    // Steady Stop switch: level only, no pulses
    apply_reset(2);
    bif.Stop_raw = 1'b1;
    start_scn();
    repeat (40) step();
    check("s6_stop_rise", 32'(stop_first), 32'd5);
    check("s6_stop_held", 32'(bif.Stop), 32'd1);
    check("s6_pulses", 32'(next_cyc.size() + pre_cyc.size() + ver_cyc.size() + rst_cyc.size()), 32'd0);
    bif.Stop_raw = 1'b0;
    repeat (10) step();

    // Random pin activity with occasional resets, checked cycle by cycle
    r = '0;
    for (int i = 0; i < 5; i++) rem[i] = $urandom_range(1, 30);
    start_scn();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (rem[i] == 0) begin
          r[i] = ~r[i];
          case ($urandom_range(0, 3))
            0:       rem[i] = $urandom_range(1, D - 1);
            1:       rem[i] = $urandom_range(D - 1, D + 1);
            default: rem[i] = $urandom_range(D, 60);
          endcase
        end
        rem[i]--;
      end
      set_raw(r);
      if ($urandom_range(0, 499) == 0) begin
        assert_reset("rnd_async");
        repeat (2) step();
        Reset_n = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
